wb_write_queue: RTL and testbench

- Write-back buffer placed directly upstream of the CPU's 32-bit register-file registers.
- Accepts write-back requests (register address + data) from the execute/memory stages through a valid/ready handshake and holds them in a small in-order FIFO.
- Drains one entry per cycle onto the register file's shared D bus, with a one-hot per-register write enable.
- Reports pending-write hazards, and forwards the youngest pending data for two read ports so decode can bypass or stall.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_write_queue_if.sv | 41 ++++
 rtl/wb_match_fwd.sv | 35 +++
 rtl/wb_write_queue.sv | 117 +++++++++++
 tb/tb_wb_write_queue.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants, entry type and address decoder for the write-back queue.
package wb_pkg;

   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned NREGS_DEF     = 16;
   localparam int unsigned WBQ_DEPTH_DEF = 4;
   localparam int unsigned AW_DEF        = $clog2(NREGS_DEF);

   typedef struct packed {
      logic                  valid;
      logic [AW_DEF-1:0]     addr;
      logic [DATA_W_DEF-1:0] data;
   } wb_entry_t;

   // Addresses with no matching register decode to all zeros.
   function automatic logic [NREGS_DEF-1:0] onehot_dec(input logic [AW_DEF-1:0] addr);
      onehot_dec = '0;
      for (int unsigned i = 0; i < NREGS_DEF; i++) begin
         if (addr == AW_DEF'(i)) onehot_dec[i] = 1'b1;
      end
   endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Request, drain, hazard/forward and status signals of the write-back queue.
interface wb_write_queue_if
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned NREGS  = NREGS_DEF,
   parameter int unsigned DEPTH  = WBQ_DEPTH_DEF
);
   localparam int unsigned AW = $clog2(NREGS);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic              in_valid;
   logic              in_ready;
   logic [AW-1:0]     in_addr;
   logic [DATA_W-1:0] in_data;
   logic              drain_stall;
   logic [NREGS-1:0]  wr_en;
   logic [DATA_W-1:0] wr_data;
   logic [AW-1:0]     rd_addr_a;
   logic [AW-1:0]     rd_addr_b;
   logic              hazard_a;
   logic              hazard_b;
   logic [DATA_W-1:0] fwd_data_a;
   logic [DATA_W-1:0] fwd_data_b;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;

   modport master (
      output in_valid, in_addr, in_data, drain_stall, rd_addr_a, rd_addr_b,
      input  in_ready, wr_en, wr_data, hazard_a, hazard_b, fwd_data_a, fwd_data_b,
             count, full, empty
   );

   modport slave (
      input  in_valid, in_addr, in_data, drain_stall, rd_addr_a, rd_addr_b,
      output in_ready, wr_en, wr_data, hazard_a, hazard_b, fwd_data_a, fwd_data_b,
             count, full, empty
   );

endinterface

// File: rtl/wb_match_fwd.sv
// Youngest-match search over the queue for one read port address.
module wb_match_fwd
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned AW     = AW_DEF,
   parameter int unsigned DEPTH  = WBQ_DEPTH_DEF
) (
   input  logic [DEPTH-1:0]         valid_i,
   input  logic [AW-1:0]            addr_i [DEPTH],
   input  logic [DATA_W-1:0]        data_i [DEPTH],
   input  logic [$clog2(DEPTH)-1:0] head_i,
   input  logic [AW-1:0]            rd_addr_i,
   output logic                     hit_o,
   output logic [DATA_W-1:0]        data_o
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0] idx;

   // Walk oldest to youngest so the last match (nearest tail) wins.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head_i + PW'(k);
         if (valid_i[idx] && (addr_i[idx] == rd_addr_i)) begin
            hit_o  = 1'b1;
            data_o = data_i[idx];
         end
      end
   end

endmodule

// File: rtl/wb_write_queue.sv
// In-order write-back FIFO draining one entry per cycle onto the register-file
// D bus, with pending-write hazard detection and youngest-data forwarding.
module wb_write_queue
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned NREGS  = NREGS_DEF,
   parameter int unsigned DEPTH  = WBQ_DEPTH_DEF
) (
   input logic            clk,
   input logic            rst,
   wb_write_queue_if.slave bus
);
   localparam int unsigned AW = $clog2(NREGS);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [AW-1:0]     addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic              full_c, empty_c, push_c, pop_c;
   logic              hit_a_c, hit_b_c;
   logic [DATA_W-1:0] fwd_a_c, fwd_b_c;

   assign full_c  = (count_q == CW'(DEPTH));
   assign empty_c = (count_q == '0);
   assign push_c  = bus.in_valid && !full_c;
   assign pop_c   = !empty_c && !bus.drain_stall;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      if (pop_c) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PW'(1);
      end
      if (push_c) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PW'(1);
      end
      if (push_c && !pop_c) begin
         count_d = count_q + CW'(1);
      end else if (pop_c && !push_c) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Payload storage needs no reset: entries are only read while valid.
   always_ff @(posedge clk) begin
      if (push_c) begin
         addr_q[tail_q] <= bus.in_addr;
         data_q[tail_q] <= bus.in_data;
      end
   end

   // Head drives the shared D bus only on a pop; out-of-range addresses enable nothing.
   always_comb begin
      bus.wr_en   = '0;
      bus.wr_data = '0;
      if (pop_c) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (addr_q[head_q] == AW'(i)) bus.wr_en[i] = 1'b1;
         end
         bus.wr_data = data_q[head_q];
      end
   end

   wb_match_fwd #(.DATA_W(DATA_W), .AW(AW), .DEPTH(DEPTH)) u_match_a (
      .valid_i   (valid_q),
      .addr_i    (addr_q),
      .data_i    (data_q),
      .head_i    (head_q),
      .rd_addr_i (bus.rd_addr_a),
      .hit_o     (hit_a_c),
      .data_o    (fwd_a_c)
   );

   wb_match_fwd #(.DATA_W(DATA_W), .AW(AW), .DEPTH(DEPTH)) u_match_b (
      .valid_i   (valid_q),
      .addr_i    (addr_q),
      .data_i    (data_q),
      .head_i    (head_q),
      .rd_addr_i (bus.rd_addr_b),
      .hit_o     (hit_b_c),
      .data_o    (fwd_b_c)
   );

   assign bus.hazard_a   = hit_a_c;
   assign bus.hazard_b   = hit_b_c;
   assign bus.fwd_data_a = fwd_a_c;
   assign bus.fwd_data_b = fwd_b_c;
   assign bus.in_ready   = !full_c;
   assign bus.full       = full_c;
   assign bus.empty      = empty_c;
   assign bus.count      = count_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-based scoreboard every cycle, a table of
// hand-derived vectors, and directed wrap/pop-hazard/reset sequences.
module tb_wb_write_queue;
   import wb_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 16;
   localparam int unsigned DP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_write_queue_if #(.DATA_W(DW), .NREGS(NR), .DEPTH(DP)) bus ();

   wb_write_queue #(.DATA_W(DW), .NREGS(NR), .DEPTH(DP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        v;
      logic [3:0]  a;
      logic [31:0] d;
      logic        st;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [2:0]  e_cnt;
      logic [15:0] e_we;
      logic [31:0] e_wd;
      logic        e_ha;
      logic [31:0] e_fa;
   } vec_t;

   vec_t      tbl [19];
   int        n_vec = 0;
   int        n_err = 0;
   wb_entry_t exp_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare every output against the queue model, then advance the model.
   task automatic model_check();
      int          sz;
      logic        pop;
      logic [15:0] e_we;
      logic [31:0] e_wd;
      logic        ha, hb;
      logic [31:0] fa, fb;
      sz = exp_q.size();
      chk("count", 32'(bus.count), 32'(sz));
      chk("full", 32'(bus.full), 32'(sz == DP));
      chk("empty", 32'(bus.empty), 32'(sz == 0));
      chk("in_ready", 32'(bus.in_ready), 32'(sz != DP));
      pop  = (sz > 0) && !bus.drain_stall;
      e_we = '0;
      e_wd = '0;
      if (pop) begin
         e_we = 16'(1) << exp_q[0].addr;
         e_wd = exp_q[0].data;
      end
      chk("wr_en", 32'(bus.wr_en), 32'(e_we));
      chk("wr_data", bus.wr_data, e_wd);
      ha = 1'b0; hb = 1'b0; fa = '0; fb = '0;
      foreach (exp_q[i]) begin
         if (exp_q[i].addr == bus.rd_addr_a) begin ha = 1'b1; fa = exp_q[i].data; end
         if (exp_q[i].addr == bus.rd_addr_b) begin hb = 1'b1; fb = exp_q[i].data; end
      end
      chk("hazard_a", 32'(bus.hazard_a), 32'(ha));
      chk("fwd_data_a", bus.fwd_data_a, fa);
      chk("hazard_b", 32'(bus.hazard_b), 32'(hb));
      chk("fwd_data_b", bus.fwd_data_b, fb);
      if (pop) void'(exp_q.pop_front());
      if (bus.in_valid && (sz != DP))
         exp_q.push_back('{valid: 1'b1, addr: bus.in_addr, data: bus.in_data});
   endtask

   task automatic cyc(input logic v, input logic [3:0] a, input logic [31:0] d,
                      input logic st, input logic [3:0] ra, input logic [3:0] rb);
      @(negedge clk);
      bus.in_valid    = v;
      bus.in_addr     = a;
      bus.in_data     = d;
      bus.drain_stall = st;
      bus.rd_addr_a   = ra;
      bus.rd_addr_b   = rb;
      #1;
      model_check();
   endtask

   initial begin
      tbl[0]  = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'd0, 3'd0, 16'h0000, 32'h0,        1'b0, 32'h0};
      tbl[1]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd5, 4'd0, 3'd1, 16'h0020, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
      tbl[2]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd5, 4'd0, 3'd0, 16'h0000, 32'h0,        1'b0, 32'h0};
      tbl[3]  = '{1'b1, 4'd1, 32'h11,       1'b1, 4'd0, 4'd0, 3'd0, 16'h0000, 32'h0,        1'b0, 32'h0};
      tbl[4]  = '{1'b1, 4'd2, 32'h22,       1'b1, 4'd0, 4'd0, 3'd1, 16'h0000, 32'h0,        1'b0, 32'h0};
      tbl[5]  = '{1'b1, 4'd3, 32'h33,       1'b1, 4'd2, 4'd0, 3'd2, 16'h0000, 32'h0,        1'b1, 32'h22};
      tbl[6]  = '{1'b1, 4'd4, 32'h44,       1'b1, 4'd0, 4'd0, 3'd3, 16'h0000, 32'h0,        1'b0, 32'h0};
      tbl[7]  = '{1'b1, 4'd6, 32'h55,       1'b1, 4'd6, 4'd0, 3'd4, 16'h0000, 32'h0,        1'b0, 32'h0};
      tbl[8]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd0, 3'd4, 16'h0002, 32'h11,       1'b0, 32'h0};
      tbl[9]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd0, 3'd3, 16'h0004, 32'h22,       1'b0, 32'h0};
      tbl[10] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd0, 3'd2, 16'h0008, 32'h33,       1'b0, 32'h0};
      tbl[11] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd0, 3'd1, 16'h0010, 32'h44,       1'b0, 32'h0};
      tbl[12] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 4'd0, 3'd0, 16'h0000, 32'h0,        1'b0, 32'h0};
      tbl[13] = '{1'b1, 4'd7, 32'hA,        1'b1, 4'd7, 4'd3, 3'd0, 16'h0000, 32'h0,        1'b0, 32'h0};
      tbl[14] = '{1'b1, 4'd7, 32'hB,        1'b1, 4'd7, 4'd3, 3'd1, 16'h0000, 32'h0,        1'b1, 32'hA};
      tbl[15] = '{1'b0, 4'd0, 32'h0,        1'b1, 4'd7, 4'd3, 3'd2, 16'h0000, 32'h0,        1'b1, 32'hB};
      tbl[16] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd7, 4'd3, 3'd2, 16'h0080, 32'hA,        1'b1, 32'hB};
      tbl[17] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd7, 4'd3, 3'd1, 16'h0080, 32'hB,        1'b1, 32'hB};
      tbl[18] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd7, 4'd3, 3'd0, 16'h0000, 32'h0,        1'b0, 32'h0};

      bus.in_valid    = 1'b0;
      bus.in_addr     = '0;
      bus.in_data     = '0;
      bus.drain_stall = 1'b0;
      bus.rd_addr_a   = '0;
      bus.rd_addr_b   = '0;

      // Reset state
      @(negedge clk);
      #1;
      model_check();
      @(negedge clk);
      rst = 1'b0;

      // Table vectors: single push/pop, full with stall, drain walk, forwarding
      foreach (tbl[i]) begin
         cyc(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].ra, tbl[i].rb);
         chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_wr_en", i), 32'(bus.wr_en), 32'(tbl[i].e_we));
         chk($sformatf("tbl%0d_wr_data", i), bus.wr_data, tbl[i].e_wd);
         chk($sformatf("tbl%0d_hazard_a", i), 32'(bus.hazard_a), 32'(tbl[i].e_ha));
         chk($sformatf("tbl%0d_fwd_a", i), bus.fwd_data_a, tbl[i].e_fa);
      end

      // Two entries held, then concurrent push/pop across the pointer wrap
      cyc(1'b1, 4'hC, 32'h100, 1'b1, 4'h0, 4'h0);
      cyc(1'b1, 4'hD, 32'h101, 1'b1, 4'h0, 4'h0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 4'(i), 32'h200 + 32'(i), 1'b0, 4'(i), 4'hD);
         chk("wrap_count", 32'(bus.count), 32'd2);
      end
      repeat (3) cyc(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0);

      // Head entry visible as a hazard in the cycle it pops, gone afterwards
      cyc(1'b1, 4'd9, 32'h99, 1'b0, 4'd9, 4'd0);
      cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd9, 4'd0);
      chk("pop_hazard_a", 32'(bus.hazard_a), 32'd1);
      chk("pop_wr_en", 32'(bus.wr_en), 32'h0200);
      cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd9, 4'd0);
      chk("after_pop_hazard_a", 32'(bus.hazard_a), 32'd0);

      // Random traffic on a narrow address range for frequent hazards
      for (int i = 0; i < 80; i++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom,
             1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      end
      while (exp_q.size() != 0) cyc(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0);

      // Asynchronous reset with three pending entries
      cyc(1'b1, 4'd1, 32'hC1, 1'b1, 4'd1, 4'd2);
      cyc(1'b1, 4'd2, 32'hC2, 1'b1, 4'd1, 4'd2);
      cyc(1'b1, 4'd3, 32'hC3, 1'b1, 4'd1, 4'd2);
      @(posedge clk);
      #1;
      chk("pre_reset_count", 32'(bus.count), 32'd3);
      bus.in_valid    = 1'b0;
      bus.drain_stall = 1'b0;
      rst             = 1'b1;
      #1;
      chk("async_reset_count", 32'(bus.count), 32'd0);
      chk("async_reset_empty", 32'(bus.empty), 32'd1);
      chk("async_reset_wr_en", 32'(bus.wr_en), 32'd0);
      chk("async_reset_hazard_a", 32'(bus.hazard_a), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (4) cyc(1'b0, 4'h0, 32'h0, 1'b0, 4'd1, 4'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
